// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, RAW policy,
// exception drain/insert sequencing, halt and stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int NSTAGES = 4,
    parameter int ADDR_W  = 32,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NSTAGES-1:0] stage_valid,
    input  logic [NSTAGES-1:0] stage_busy,
    input  logic               queue_full,
    input  logic [4:0]         rs1_e,
    input  logic [4:0]         rs2_e,
    input  logic [4:0]         rd_m,
    input  logic               reg_write_m,
    input  logic               dren_m,
    input  logic               mispredict,
    input  logic               serialize_req,
    input  logic               exception_req,
    input  logic [ADDR_W-1:0]  tvec,
    input  logic               halt_req,
    output logic [NSTAGES-1:0] stall,
    output logic [NSTAGES-1:0] flush,
    output logic               pc_en,
    output logic               npc_sel,
    output logic               rollback,
    output logic               insert_priv_pc,
    output logic [ADDR_W-1:0]  priv_pc,
    output logic               suppress_iren,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_count
);

    localparam int MEM = NSTAGES - 1;
    localparam int EX  = NSTAGES - 2;

    localparam logic [NSTAGES-1:0] ALL   = '1;
    localparam logic [NSTAGES-1:0] FRONT = ALL >> 1;
    localparam logic [NSTAGES-1:0] MEMB  = ALL ^ FRONT;
    localparam logic [NSTAGES-1:0] FETCH = {{(NSTAGES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CMAX  = '1;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_INSERT,
        S_IFLUSH,
        S_HALTED
    } state_t;

    state_t state, state_n;

    logic [NSTAGES-1:0] hold;
    logic [NSTAGES-1:0] stall_c;
    logic [NSTAGES-1:0] flush_c;
    logic               pc_en_c;
    logic               npc_c;
    logic               rb_c;
    logic               ins_c;
    logic               sup_c;
    logic               halt_c;
    logic               latch_pc;

    logic raw_any;
    logic hazard;
    logic ev_halt;
    logic ev_exc;
    logic ev_ser;
    logic ev_mis;
    logic unused_valid;

    assign unused_valid = ^stage_valid;

    assign raw_any = stage_valid[EX] & stage_valid[MEM]
                   & reg_write_m & (rd_m != 5'd0)
                   & ((rd_m == rs1_e) | (rd_m == rs2_e));

    assign hazard = (FWD_EN != 0) ? (raw_any & dren_m) : raw_any;

    assign ev_halt = halt_req      & stage_valid[MEM];
    assign ev_exc  = exception_req & stage_valid[MEM];
    assign ev_ser  = serialize_req & stage_valid[MEM];
    assign ev_mis  = mispredict    & stage_valid[MEM];

    // Back-pressure chain: a busy stage holds itself and all older stages
    always_comb begin
        hold = '0;
        hold[MEM] = stage_busy[MEM];
        for (int i = MEM - 1; i >= 0; i--) begin
            hold[i] = stage_busy[i] | hold[i+1];
            if (i == 1 && NSTAGES >= 4) begin
                hold[i] = hold[i] | (queue_full & stage_valid[1]);
            end
        end
    end

    // Next-state and per-stage control decode
    always_comb begin
        state_n  = state;
        stall_c  = '0;
        flush_c  = '0;
        pc_en_c  = 1'b0;
        npc_c    = 1'b0;
        rb_c     = 1'b0;
        ins_c    = 1'b0;
        sup_c    = 1'b0;
        halt_c   = 1'b0;
        latch_pc = 1'b0;
        case (state)
            S_RUN: begin
                if (ev_halt) begin
                    stall_c = hold;
                    flush_c = FRONT;
                    state_n = S_HALTED;
                end else if (ev_exc) begin
                    latch_pc = 1'b1;
                    if (stage_busy[MEM]) begin
                        stall_c = ALL;
                        state_n = S_DRAIN;
                    end else begin
                        flush_c = ALL;
                        state_n = S_INSERT;
                    end
                end else if (ev_ser && !hold[MEM]) begin
                    rb_c    = 1'b1;
                    flush_c = FRONT;
                    pc_en_c = 1'b1;
                end else if (ev_mis && !hold[MEM]) begin
                    npc_c   = 1'b1;
                    flush_c = FRONT;
                    pc_en_c = 1'b1;
                end else if (hazard && !hold[MEM]) begin
                    stall_c = FRONT;
                    flush_c = MEMB;
                end else begin
                    stall_c = hold;
                    pc_en_c = !hold[0];
                end
            end
            S_DRAIN: begin
                stall_c = ALL;
                if (!stage_busy[MEM]) begin
                    flush_c = ALL;
                    state_n = S_INSERT;
                end
            end
            S_INSERT: begin
                ins_c   = 1'b1;
                pc_en_c = 1'b1;
                flush_c = ALL;
                state_n = stage_busy[0] ? S_IFLUSH : S_RUN;
            end
            S_IFLUSH: begin
                sup_c   = 1'b1;
                flush_c = FETCH;
                if (!stage_busy[0]) begin
                    state_n = S_RUN;
                end
            end
            S_HALTED: begin
                halt_c  = 1'b1;
                stall_c = ALL;
                sup_c   = 1'b1;
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    assign stall          = nRST ? (stall_c & ~flush_c) : '0;
    assign flush          = nRST ? flush_c : '0;
    assign pc_en          = nRST & pc_en_c;
    assign npc_sel        = nRST & npc_c;
    assign rollback       = nRST & rb_c;
    assign insert_priv_pc = nRST & ins_c;
    assign suppress_iren  = nRST & sup_c;
    assign halted         = nRST & halt_c;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_RUN;
        end else begin
            state <= state_n;
        end
    end

    // Trap vector capture on exception entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            priv_pc <= '0;
        end else if (latch_pc) begin
            priv_pc <= tvec;
        end
    end

    // Saturating count of fetch-stall cycles, frozen while halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
        end else if (stall[0] && state != S_HALTED
                     && stall_count != CMAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle
// expectations queued at drive time and compared at the falling edge.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        nRST;
    logic [3:0]  stage_valid;
    logic [3:0]  stage_busy;
    logic        queue_full;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_m;
    logic        reg_write_m;
    logic        dren_m;
    logic        mispredict;
    logic        serialize_req;
    logic        exception_req;
    logic [31:0] tvec;
    logic        halt_req;

    logic [3:0]  stall_a, flush_a;
    logic        pc_en_a, npc_a, rb_a, ins_a, sup_a, hlt_a;
    logic [31:0] ppc_a;
    logic [3:0]  cnt_a;

    logic [3:0]  stall_b, flush_b;
    logic        pc_en_b, npc_b, rb_b, ins_b, sup_b, hlt_b;
    logic [31:0] ppc_b;
    logic [3:0]  cnt_b;

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  fl;
        logic [3:0]  st_b;
        logic [3:0]  fl_b;
        logic        pe;
        logic        np;
        logic        rb;
        logic        ins;
        logic        sup;
        logic        hl;
        logic [31:0] ppc;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ep;
    logic [3:0]  ecnt;

    pipeline_hazard_ctrl #(
        .NSTAGES(4), .ADDR_W(32), .FWD_EN(1), .CNT_W(4)
    ) u_dut (
        .CLK(CLK), .nRST(nRST),
        .stage_valid(stage_valid), .stage_busy(stage_busy),
        .queue_full(queue_full),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m),
        .reg_write_m(reg_write_m), .dren_m(dren_m),
        .mispredict(mispredict), .serialize_req(serialize_req),
        .exception_req(exception_req), .tvec(tvec),
        .halt_req(halt_req),
        .stall(stall_a), .flush(flush_a), .pc_en(pc_en_a),
        .npc_sel(npc_a), .rollback(rb_a),
        .insert_priv_pc(ins_a), .priv_pc(ppc_a),
        .suppress_iren(sup_a), .halted(hlt_a),
        .stall_count(cnt_a)
    );

    pipeline_hazard_ctrl #(
        .NSTAGES(4), .ADDR_W(32), .FWD_EN(0), .CNT_W(4)
    ) u_dut_nofwd (
        .CLK(CLK), .nRST(nRST),
        .stage_valid(stage_valid), .stage_busy(stage_busy),
        .queue_full(queue_full),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m),
        .reg_write_m(reg_write_m), .dren_m(dren_m),
        .mispredict(mispredict), .serialize_req(serialize_req),
        .exception_req(exception_req), .tvec(tvec),
        .halt_req(halt_req),
        .stall(stall_b), .flush(flush_b), .pc_en(pc_en_b),
        .npc_sel(npc_b), .rollback(rb_b),
        .insert_priv_pc(ins_b), .priv_pc(ppc_b),
        .suppress_iren(sup_b), .halted(hlt_b),
        .stall_count(cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%h want=%h",
                     tag, $time, got, want);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stall",    32'(stall_a), 32'(e.st));
            chk("flush",    32'(flush_a), 32'(e.fl));
            chk("stall_nf", 32'(stall_b), 32'(e.st_b));
            chk("flush_nf", 32'(flush_b), 32'(e.fl_b));
            chk("pc_en",    32'(pc_en_a), 32'(e.pe));
            chk("npc_sel",  32'(npc_a),   32'(e.np));
            chk("rollback", 32'(rb_a),    32'(e.rb));
            chk("ins_ppc",  32'(ins_a),   32'(e.ins));
            chk("supp",     32'(sup_a),   32'(e.sup));
            chk("halted",   32'(hlt_a),   32'(e.hl));
            chk("priv_pc",  ppc_a,        e.ppc);
            chk("cnt",      32'(cnt_a),   32'(e.cnt));
        end
    end

    task automatic put(input logic [3:0] st, input logic [3:0] fl,
                       input logic [3:0] stb, input logic [3:0] flb,
                       input logic pe, input logic np, input logic rb,
                       input logic ins, input logic sup, input logic hl);
        exp_t e;
        e.st = st; e.fl = fl; e.st_b = stb; e.fl_b = flb;
        e.pe = pe; e.np = np; e.rb = rb; e.ins = ins;
        e.sup = sup; e.hl = hl; e.ppc = ep; e.cnt = ecnt;
        sb.push_back(e);
        if (st[0] && !hl && ecnt != 4'hf) ecnt = ecnt + 4'd1;
        @(posedge CLK);
        #1;
    endtask

    task automatic put_s(input logic [3:0] st, input logic [3:0] fl,
                         input logic pe, input logic np, input logic rb,
                         input logic ins, input logic sup, input logic hl);
        put(st, fl, st, fl, pe, np, rb, ins, sup, hl);
    endtask

    task automatic idle();
        stage_valid   = 4'b1111;
        stage_busy    = 4'b0000;
        queue_full    = 1'b0;
        rs1_e         = 5'd0;
        rs2_e         = 5'd0;
        rd_m          = 5'd0;
        reg_write_m   = 1'b1;
        dren_m        = 1'b1;
        mispredict    = 1'b0;
        serialize_req = 1'b0;
        exception_req = 1'b0;
        tvec          = 32'h0;
        halt_req      = 1'b0;
    endtask

    task automatic rst_checks(input string pfx);
        chk({pfx, "_stall"}, 32'(stall_a), 32'h0);
        chk({pfx, "_flush"}, 32'(flush_a), 32'h0);
        chk({pfx, "_pc_en"}, 32'(pc_en_a), 32'h0);
        chk({pfx, "_supp"},  32'(sup_a),   32'h0);
        chk({pfx, "_halt"},  32'(hlt_a),   32'h0);
        chk({pfx, "_ppc"},   ppc_a,        32'h0);
        chk({pfx, "_cnt"},   32'(cnt_a),   32'h0);
    endtask

    initial begin
        ep   = 32'h0;
        ecnt = 4'h0;
        nRST = 1'b0;
        idle();
        #1;
        rst_checks("rst");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        rd_m = 5'd5; rs1_e = 5'd5;
        put_s(4'b0111, 4'b1000, 0, 0, 0, 0, 0, 0);
        rd_m = 5'd0;
        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        rd_m = 5'd7; rs2_e = 5'd7; rs1_e = 5'd0; dren_m = 1'b0;
        put(4'b0000, 4'b0000, 4'b0111, 4'b1000, 1, 0, 0, 0, 0, 0);
        idle();

        mispredict = 1'b1;
        put_s(4'b0000, 4'b0111, 1, 1, 0, 0, 0, 0);
        stage_valid = 4'b0111;
        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        idle();

        stage_busy = 4'b0010;
        put_s(4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0);
        stage_busy = 4'b0000; queue_full = 1'b1;
        put_s(4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0);
        queue_full = 1'b0;

        serialize_req = 1'b1;
        put_s(4'b0000, 4'b0111, 1, 0, 1, 0, 0, 0);
        stage_busy = 4'b1000;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        serialize_req = 1'b0;

        exception_req = 1'b1; tvec = 32'h200;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        exception_req = 1'b0; tvec = 32'h0; ep = 32'h200;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        stage_busy = 4'b0000;
        put_s(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0);
        stage_busy = 4'b0001;
        put_s(4'b0000, 4'b1111, 1, 0, 0, 1, 0, 0);
        put_s(4'b0000, 4'b0001, 0, 0, 0, 0, 1, 0);
        stage_busy = 4'b0000;
        put_s(4'b0000, 4'b0001, 0, 0, 0, 0, 1, 0);
        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        stage_busy = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        end

        exception_req = 1'b1; tvec = 32'h200;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        exception_req = 1'b0;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        rst_checks("drain_rst");
        idle();
        ep   = 32'h0;
        ecnt = 4'h0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        halt_req = 1'b1; exception_req = 1'b1; mispredict = 1'b1;
        tvec = 32'h300;
        put_s(4'b0000, 4'b0111, 0, 0, 0, 0, 0, 0);
        idle();
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 1, 1);
        mispredict = 1'b1;
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 1, 1);
        idle();
        put_s(4'b1111, 4'b0000, 0, 0, 0, 0, 1, 1);
        nRST = 1'b0;
        #1;
        rst_checks("halt_rst");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        put_s(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge CLK);
        end
        if (sb.size() != 0) begin
            n_tot++;
            n_bad++;
            $display("FAIL drain_q: left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor to the fixed four-stage hazard unit.
- Generates per-stage stall/flush vectors for an NSTAGES in-order pipeline: stage 0 = fetch, EX = NSTAGES-2, MEM = NSTAGES-1.
- Adds a configurable RAW policy, an exception drain/insert state machine, a terminal halt state, and a saturating stall-cycle counter.
- Sits beside the pipeline and drives fetch PC control and every stage's hold/clear.

Parameters:
- NSTAGES, 4, pipeline depth, minimum 3.
- ADDR_W, 32, PC/vector width.
- FWD_EN, 1, 1 = forwarding present, only load-use stalls; 0 = any RAW on rd_m stalls.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- stage_valid  in  NSTAGES  stage i holds a valid instruction
- stage_busy  in  NSTAGES  stage i cannot complete this cycle (bit 0 = imem busy, bit MEM = dmem busy)
- queue_full  in  1  decode queue full; holds stage 1 when NSTAGES>=4, ignored otherwise
- rs1_e, rs2_e  in  5  EX source registers
- rd_m  in  5  MEM destination register
- reg_write_m  in  1  MEM writes rd_m
- dren_m  in  1  MEM is a load
- mispredict  in  1  branch/jump redirect resolved in MEM
- serialize_req  in  1  ifence/CSR write in MEM needing refetch
- exception_req  in  1  MEM instruction traps
- tvec  in  ADDR_W  trap vector
- halt_req  in  1  MEM halt
- stall  out  NSTAGES  stage i keeps its contents next edge
- flush  out  NSTAGES  stage i cleared to bubble next edge
- pc_en  out  1  fetch PC update enable
- npc_sel  out  1  select MEM-resolved target
- rollback  out  1  refetch from MEM pc+4
- insert_priv_pc  out  1  load priv_pc into PC
- priv_pc  out  ADDR_W  latched trap vector
- suppress_iren  out  1  discard/inhibit instruction fetch
- halted  out  1  core halted
- stall_count  out  CNT_W  cycles with stall[0] set

Behaviour:
- Bit i of every vector refers to stage i. flush overrides stall in the same bit.
- Hold chain: hold[MEM] = stage_busy[MEM]; for i<MEM, hold[i] = stage_busy[i] | hold[i+1]; hold[1] is also set by queue_full & stage_valid[1].
- RAW hazard: stage_valid[EX] & stage_valid[MEM] & reg_write_m & rd_m!=0 & (rd_m==rs1_e | rd_m==rs2_e), further ANDed with dren_m when FWD_EN=1.
- When hazard & !hold[MEM]: stall[0..EX]=1, flush[MEM]=1, pc_en=0.
- In RUN otherwise: stall = hold; pc_en = !stall[0].
- FSM states: RUN, DRAIN, INSERT, IFLUSH, HALTED. Events are qualified by stage_valid[MEM]. Priority: halt_req > exception_req > serialize_req > mispredict > RAW > hold.
- RUN, halt: flush[0..EX], pc_en=0; next state HALTED.
- RUN, exception: latch priv_pc<=tvec.
  - If stage_busy[MEM]: stall all, pc_en=0, next state DRAIN.
  - Else: flush all, next state INSERT.
- RUN, serialize & !hold[MEM]: rollback=1, flush[0..EX], pc_en=1; stay in RUN.
- RUN, mispredict & !hold[MEM]: npc_sel=1, pc_en=1, flush[0..EX].
- DRAIN: stall all, pc_en=0. When !stage_busy[MEM]: flush all, next state INSERT.
- INSERT (exactly 1 cycle): insert_priv_pc=1, pc_en=1, flush all. Next state IFLUSH if stage_busy[0], else RUN.
- IFLUSH: suppress_iren=1, flush[0]=1, stall[1..MEM]=0, pc_en=0. Next state RUN when !stage_busy[0].
- HALTED: halted=1, stall all, pc_en=0, suppress_iren=1. Left only by reset.
- stall_count: +1 each cycle stall[0]=1 and state!=HALTED; saturates at 2^CNT_W-1.
- Reset (async, any state, including mid-DRAIN/INSERT):
  - state=RUN, priv_pc=0, stall_count=0.
  - All outputs 0 while nRST low.

Test Plan:
- NSTAGES=4, FWD_EN=1; stage_valid=1111, dren_m=1, reg_write_m=1, rd_m=5, rs1_e=5 -> stall=0111, flush=1000, pc_en=0 for one cycle. Same with rd_m=0 -> no stall.
- FWD_EN=0; rd_m=7, rs2_e=7, dren_m=0 -> stall=0111, flush=1000. FWD_EN=1 -> stall=0000.
- mispredict with stage_valid[3]=1, busy=0 -> flush=0111, npc_sel=1, pc_en=1 for one cycle.
- exception_req, tvec=0x200, stage_busy[3] high 3 cycles then stage_busy[0] high 2 cycles:
  - 3 cycles of stall=1111;
  - flush=1111;
  - INSERT with insert_priv_pc=1, priv_pc=0x200;
  - 2 cycles suppress_iren=1;
  - back to RUN.
- halt_req+exception_req+mispredict same cycle -> halt wins: flush=0111, halted=1 from next cycle, persists until nRST; stall_count frozen.
- CNT_W=4, stage_busy[3] held 20 cycles -> stall_count saturates at 15. nRST pulsed mid-DRAIN -> outputs 0 immediately, RUN and priv_pc=0 after release.
